prach_job_scheduler: RTL

//  Per-packet sequencer in front of module_top (PRACH detector).
//  - Queues per-job detector settings from a host write port.
//  - For each job, applies the settings before the packet reaches module_top, then gates the

---
 rtl/prach_ctrl_pkg.sv | 21 ++
 rtl/prach_cfg_fifo.sv | 54 +++++
 rtl/prach_job_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/prach_ctrl_pkg.sv
// rtl/prach_ctrl_pkg.sv - shared types for the PRACH job scheduler
package prach_ctrl_pkg;

    localparam int CFG_W = 25;

    typedef struct packed {
        logic [11:0] root;
        logic [6:0]  num;
        logic [1:0]  fmt;
        logic [3:0]  zcz;
    } prach_cfg_t;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        STREAM,
        WAIT_RES,
        REPORT
    } sched_state_t;

endpackage

// File: rtl/prach_cfg_fifo.sv
// rtl/prach_cfg_fifo.sv - job config queue with registered read port
module prach_cfg_fifo
    import prach_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr_en,
    input  logic [CFG_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [CFG_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [CFG_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // rd_data only moves on a pop, so it doubles as the applied-settings register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/prach_job_scheduler.sv
// rtl/prach_job_scheduler.sv - per-packet settings sequencer and stream gate for the PRACH detector
module prach_job_scheduler
    import prach_ctrl_pkg::*;
#(
    parameter int BW_DATA     = 32,
    parameter int BW_USER     = 4,
    parameter int CFG_DEPTH   = 4,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               cfg_wr_valid,
    output logic               cfg_wr_ready,
    input  logic [3:0]         cfg_wr_zcz,
    input  logic [1:0]         cfg_wr_fmt,
    input  logic [6:0]         cfg_wr_num,
    input  logic [11:0]        cfg_wr_root,
    input  logic [BW_DATA-1:0] axiRx_Data,
    input  logic               axiRx_Valid,
    input  logic               axiRx_Last,
    input  logic [BW_USER-1:0] axiRx_User,
    output logic               axiRx_Ready,
    output logic [BW_DATA-1:0] axiTx_Data,
    output logic               axiTx_Valid,
    output logic               axiTx_Last,
    output logic [BW_USER-1:0] axiTx_User,
    input  logic               axiTx_Ready,
    output logic [3:0]         zeroCorrelationZone,
    output logic [1:0]         preamble_format,
    output logic [6:0]         num_preambl,
    output logic [11:0]        ROOT_SEQ,
    input  logic               det_done,
    input  logic [6:0]         count_preambles,
    input  logic               no_prach_detected,
    output logic               job_done,
    output logic [6:0]         job_count,
    output logic               job_no_prach,
    output logic               job_timeout,
    output logic [15:0]        jobs_completed,
    output logic               busy
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] to_cnt;
    prach_cfg_t    wr_cfg;
    prach_cfg_t    cur_cfg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          in_stream;
    logic          last_hs;
    logic          settle_end;
    logic          timeout_hit;

    assign wr_cfg.root = cfg_wr_root;
    assign wr_cfg.num  = cfg_wr_num;
    assign wr_cfg.fmt  = cfg_wr_fmt;
    assign wr_cfg.zcz  = cfg_wr_zcz;

    assign cfg_wr_ready = !fifo_full;
    assign pop          = (state == IDLE) && !fifo_empty;

    prach_cfg_fifo #(
        .DEPTH (CFG_DEPTH)
    ) u_cfg_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en   (cfg_wr_valid),
        .wr_data (wr_cfg),
        .rd_en   (pop),
        .rd_data (cur_cfg),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign zeroCorrelationZone = cur_cfg.zcz;
    assign preamble_format     = cur_cfg.fmt;
    assign num_preambl         = cur_cfg.num;
    assign ROOT_SEQ            = cur_cfg.root;

    // Sideband always mirrors the source; only the handshake is gated.
    assign in_stream   = (state == STREAM);
    assign axiTx_Data  = axiRx_Data;
    assign axiTx_Last  = axiRx_Last;
    assign axiTx_User  = axiRx_User;
    assign axiTx_Valid = in_stream && axiRx_Valid;
    assign axiRx_Ready = in_stream && axiTx_Ready;

    assign last_hs     = in_stream && axiRx_Valid && axiTx_Ready && axiRx_Last;
    assign settle_end  = (settle_cnt == SW'(SETTLE_CYC - 1));
    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));

    assign job_done = (state == REPORT);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!fifo_empty)              state_nxt = SETTLE;
            SETTLE:   if (settle_end)               state_nxt = STREAM;
            STREAM:   if (last_hs)                  state_nxt = WAIT_RES;
            WAIT_RES: if (det_done || timeout_hit)  state_nxt = REPORT;
            REPORT:                                 state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            to_cnt         <= '0;
            job_count      <= '0;
            job_no_prach   <= 1'b0;
            job_timeout    <= 1'b0;
            jobs_completed <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:   settle_cnt <= '0;
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                STREAM: to_cnt     <= '0;
                WAIT_RES: begin
                    to_cnt <= to_cnt + 1'b1;
                    // A result arriving on the expiry cycle still counts as a real result.
                    if (det_done) begin
                        job_count    <= count_preambles;
                        job_no_prach <= no_prach_detected;
                        job_timeout  <= 1'b0;
                    end else if (timeout_hit) begin
                        job_count    <= '0;
                        job_no_prach <= 1'b1;
                        job_timeout  <= 1'b1;
                    end
                end
                REPORT: jobs_completed <= jobs_completed + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
